// File: rtl/pit_pkg.sv
// Shared types and helpers for the PIT bus sequencer.
// Readback support is selected in pit_ctrl by the PIT_CTRL_READBACK_EN macro.
package pit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CW,
        CWGAP,
        B0,
        B0GAP,
        B1,
        B1GAP,
        RSP
    } pit_state_t;

    typedef enum logic {
        OP_PROGRAM  = 1'b0,
        OP_READBACK = 1'b1
    } pit_op_t;

    localparam logic [1:0] A_CTRL     = 2'b11;
    localparam logic [1:0] RL_LSB_MSB = 2'b11;
    localparam logic [1:0] RL_LATCH   = 2'b00;

    typedef struct packed {
        logic       cs;
        logic       rd;
        logic       wr;
        logic [1:0] a;
        logic [7:0] wdata;
    } pit_bus_t;

    localparam pit_bus_t BUS_IDLE = '0;

    // One strobe cycle: reads leave wdata at zero.
    function automatic pit_bus_t bus_cycle(pit_op_t op, logic [1:0] a, logic [7:0] wdata);
        pit_bus_t b;
        b    = BUS_IDLE;
        b.cs = 1'b1;
        b.a  = a;
        if (op == OP_READBACK) begin
            b.rd = 1'b1;
        end else begin
            b.wr    = 1'b1;
            b.wdata = wdata;
        end
        return b;
    endfunction

    function automatic logic [7:0] ctrl_word(pit_op_t op, logic [1:0] ch, logic [2:0] mode,
                                             logic bcd);
        if (op == OP_READBACK)
            return {ch, RL_LATCH, 4'b0000};
        else
            return {ch, RL_LSB_MSB, mode, bcd};
    endfunction

endpackage

// File: rtl/pit_rr_arb.sv
// Two-requester round-robin grant; the pointer flips to the other requester
// after every accepted command.
module pit_rr_arb
    import pit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (en && !reset) begin
            if (ptr == 1'b0)
                grant = req[0] ? 2'b01 : (req[1] ? 2'b10 : 2'b00);
            else
                grant = req[1] ? 2'b10 : (req[0] ? 2'b01 : 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= 1'b0;
        else if (grant[0])
            ptr <= 1'b1;
        else if (grant[1])
            ptr <= 1'b0;
    end

endmodule

// File: rtl/pit_ctrl.sv
// Sequences program/readback commands from two requesters onto an 8254-style timer bus.
// Define PIT_CTRL_READBACK_EN to implement readback; otherwise readback completes as an error.
//
// state | meaning
// IDLE  | waiting for a request, grant is combinational
// CW    | control word write strobe
// CWGAP | GAP idle cycles after the control word
// B0    | low byte write or read strobe
// B0GAP | GAP idle cycles after the low byte
// B1    | high byte write or read strobe
// B1GAP | GAP idle cycles after the high byte
// RSP   | one-cycle completion pulse to the owner
module pit_ctrl
    import pit_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_op,
    input  logic [3:0]  req_ch,
    input  logic [5:0]  req_mode,
    input  logic [1:0]  req_bcd,
    input  logic [31:0] req_value,
    output logic [1:0]  rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        pit_cs,
    output logic        pit_rd,
    output logic        pit_wr,
    output logic [1:0]  pit_a,
    output logic [7:0]  pit_wdata,
    input  logic [7:0]  pit_rdata
);

    localparam logic [2:0] GAP_LOAD = 3'(GAP - 1);

    pit_state_t  state;
    pit_bus_t    bus_r;
    logic        owner;
    pit_op_t     op_r;
    logic [1:0]  ch_r;
    logic [15:0] value_r;
    logic [2:0]  gap_cnt;

    logic [1:0]  grant;
    logic        accept;
    logic        sel;
    pit_op_t     acc_op;
    logic [1:0]  acc_ch;
    logic [2:0]  acc_mode;
    logic        acc_bcd;
    logic [15:0] acc_value;
    logic        acc_err;

    pit_rr_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (state == IDLE),
        .req   (req_valid),
        .grant (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign sel       = grant[1];

    assign acc_op    = pit_op_t'(req_op[sel]);
    assign acc_ch    = sel ? req_ch[3:2]       : req_ch[1:0];
    assign acc_mode  = sel ? req_mode[5:3]     : req_mode[2:0];
    assign acc_bcd   = req_bcd[sel];
    assign acc_value = sel ? req_value[31:16]  : req_value[15:0];

`ifdef PIT_CTRL_READBACK_EN
    assign acc_err = (acc_ch == 2'd3);
`else
    assign acc_err = (acc_ch == 2'd3) || (acc_op == OP_READBACK);
`endif

    assign busy = !reset && ((state != IDLE) || accept);

    assign pit_cs    = bus_r.cs;
    assign pit_rd    = bus_r.rd;
    assign pit_wr    = bus_r.wr;
    assign pit_a     = bus_r.a;
    assign pit_wdata = bus_r.wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bus_r     <= BUS_IDLE;
            owner     <= 1'b0;
            op_r      <= OP_PROGRAM;
            ch_r      <= 2'd0;
            value_r   <= 16'd0;
            gap_cnt   <= 3'd0;
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;
            rsp_data  <= 16'd0;
        end else begin
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner    <= sel;
                        op_r     <= acc_op;
                        ch_r     <= acc_ch;
                        value_r  <= acc_value;
                        rsp_data <= 16'd0;
                        if (acc_err) begin
                            rsp_valid <= grant;
                            rsp_err   <= 1'b1;
                            state     <= RSP;
                        end else begin
                            bus_r <= bus_cycle(OP_PROGRAM, A_CTRL,
                                               ctrl_word(acc_op, acc_ch, acc_mode, acc_bcd));
                            state <= CW;
                        end
                    end
                end
                CW: begin
                    bus_r   <= BUS_IDLE;
                    gap_cnt <= GAP_LOAD;
                    state   <= CWGAP;
                end
                CWGAP: begin
                    if (gap_cnt == 3'd0) begin
                        bus_r <= bus_cycle(op_r, ch_r, value_r[7:0]);
                        state <= B0;
                    end else begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end
                end
                B0: begin
                    bus_r   <= BUS_IDLE;
                    gap_cnt <= GAP_LOAD;
                    if (op_r == OP_READBACK)
                        rsp_data[7:0] <= pit_rdata;
                    state   <= B0GAP;
                end
                B0GAP: begin
                    if (gap_cnt == 3'd0) begin
                        bus_r <= bus_cycle(op_r, ch_r, value_r[15:8]);
                        state <= B1;
                    end else begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end
                end
                B1: begin
                    bus_r   <= BUS_IDLE;
                    gap_cnt <= GAP_LOAD;
                    if (op_r == OP_READBACK)
                        rsp_data[15:8] <= pit_rdata;
                    state   <= B1GAP;
                end
                B1GAP: begin
                    if (gap_cnt == 3'd0) begin
                        rsp_valid <= owner ? 2'b10 : 2'b01;
                        state     <= RSP;
                    end else begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end
                end
                RSP: begin
                    state <= IDLE;
                end
                default: begin
                    bus_r <= BUS_IDLE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pit_ctrl.sv
// Directed bench for pit_ctrl: vector table at GAP=1, plus round-robin, mid-sequence
// reset and GAP=3 timing sequences.
module tb_pit_ctrl;

`ifdef PIT_CTRL_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  req_valid, req_valid3, req_ready, req_ready3;
    logic [1:0]  req_op, req_bcd, rsp_valid, rsp_valid3;
    logic [3:0]  req_ch;
    logic [5:0]  req_mode;
    logic [31:0] req_value;
    logic [15:0] rsp_data, rsp_data3;
    logic        rsp_err, rsp_err3, busy, busy3;
    logic        pit_cs, pit_rd, pit_wr, pit_cs3, pit_rd3, pit_wr3;
    logic [1:0]  pit_a, pit_a3;
    logic [7:0]  pit_wdata, pit_wdata3, pit_rdata;

    // Bus model: first read of a command returns rd_lo, later reads rd_hi.
    logic [7:0] rd_lo = 8'h00, rd_hi = 8'h00;
    int rd_idx = 0, rd_start = 0, cyc = 0;
    assign pit_rdata = (rd_idx == rd_start) ? rd_lo : rd_hi;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pit_rd) rd_idx <= rd_idx + 1;
    end

    pit_ctrl #(.GAP(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_ch(req_ch), .req_mode(req_mode), .req_bcd(req_bcd),
        .req_value(req_value), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy), .pit_cs(pit_cs), .pit_rd(pit_rd),
        .pit_wr(pit_wr), .pit_a(pit_a), .pit_wdata(pit_wdata), .pit_rdata(pit_rdata)
    );

    pit_ctrl #(.GAP(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_op(req_op), .req_ch(req_ch), .req_mode(req_mode), .req_bcd(req_bcd),
        .req_value(req_value), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
        .rsp_err(rsp_err3), .busy(busy3), .pit_cs(pit_cs3), .pit_rd(pit_rd3),
        .pit_wr(pit_wr3), .pit_a(pit_a3), .pit_wdata(pit_wdata3), .pit_rdata(pit_rdata)
    );

    typedef struct {
        int          r;
        logic        op;
        logic [1:0]  ch;
        logic [2:0]  mode;
        logic        bcd;
        logic [15:0] value;
        logic [7:0]  rlo;
        logic [7:0]  rhi;
        logic        err;
        logic [7:0]  cw;
        logic [15:0] data;
    } vec_t;

    vec_t vecs[7];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic drive(input vec_t v);
        req_op[v.r]            = v.op;
        req_ch[2*v.r +: 2]     = v.ch;
        req_mode[3*v.r +: 3]   = v.mode;
        req_bcd[v.r]           = v.bcd;
        req_value[16*v.r +: 16] = v.value;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Accept at cycle T, then check cycles T+1..T+8 against the GAP=1 timeline.
    task automatic run_vec(input int idx, input vec_t v);
        logic [2:0] exp_str;
        logic [7:0] exp_wd;
        int rsp_k;
        @(negedge clk);
        rd_lo    = v.rlo;
        rd_hi    = v.rhi;
        rd_start = rd_idx;
        drive(v);
        req_valid = 2'(1 << v.r);
        #1;
        check($sformatf("v%0d ready", idx), 32'(req_ready), 32'(1 << v.r));
        check($sformatf("v%0d busy_accept", idx), 32'(busy), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        rsp_k = v.err ? 1 : 7;
        for (int k = 1; k <= 8; k++) begin
            exp_str = 3'b000;
            if (!v.err && (k == 1 || k == 3 || k == 5))
                exp_str = (k == 1 || !v.op) ? 3'b101 : 3'b110;
            check($sformatf("v%0d strobes k%0d", idx, k), 32'({pit_cs, pit_rd, pit_wr}),
                  32'(exp_str));
            if (exp_str[2])
                check($sformatf("v%0d pit_a k%0d", idx, k), 32'(pit_a),
                      (k == 1) ? 32'd3 : 32'(v.ch));
            if (exp_str[0]) begin
                exp_wd = (k == 1) ? v.cw : ((k == 3) ? v.value[7:0] : v.value[15:8]);
                check($sformatf("v%0d wdata k%0d", idx, k), 32'(pit_wdata), 32'(exp_wd));
            end
            check($sformatf("v%0d rsp_valid k%0d", idx, k), 32'(rsp_valid),
                  (k == rsp_k) ? 32'(1 << v.r) : 32'd0);
            if (k == rsp_k) begin
                check($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.err));
                if (v.op && !v.err)
                    check($sformatf("v%0d rsp_data", idx), 32'(rsp_data), 32'(v.data));
            end
            check($sformatf("v%0d busy k%0d", idx, k), 32'(busy), (k <= rsp_k) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   last_cyc;
        int   found;
        logic [2:0] e3;

        vecs[0] = '{r:0, op:1'b0, ch:2'd1, mode:3'd3, bcd:1'b0, value:16'h1234,
                    rlo:8'h00, rhi:8'h00, err:1'b0, cw:8'h76, data:16'h0000};
        vecs[1] = '{r:1, op:1'b1, ch:2'd2, mode:3'd0, bcd:1'b0, value:16'h0000,
                    rlo:8'hCD, rhi:8'hAB, err:(RB ? 1'b0 : 1'b1), cw:8'h80, data:16'hABCD};
        vecs[2] = '{r:1, op:1'b0, ch:2'd0, mode:3'd7, bcd:1'b1, value:16'h0000,
                    rlo:8'h00, rhi:8'h00, err:1'b0, cw:8'h3F, data:16'h0000};
        vecs[3] = '{r:0, op:1'b0, ch:2'd2, mode:3'd6, bcd:1'b0, value:16'hFFFF,
                    rlo:8'h00, rhi:8'h00, err:1'b0, cw:8'hBC, data:16'h0000};
        vecs[4] = '{r:0, op:1'b0, ch:2'd3, mode:3'd2, bcd:1'b0, value:16'h5555,
                    rlo:8'h00, rhi:8'h00, err:1'b1, cw:8'h00, data:16'h0000};
        vecs[5] = '{r:1, op:1'b1, ch:2'd3, mode:3'd0, bcd:1'b0, value:16'h0000,
                    rlo:8'h11, rhi:8'h22, err:1'b1, cw:8'h00, data:16'h0000};
        vecs[6] = '{r:0, op:1'b1, ch:2'd0, mode:3'd0, bcd:1'b0, value:16'h0000,
                    rlo:8'h5A, rhi:8'hA5, err:(RB ? 1'b0 : 1'b1), cw:8'h00, data:16'hA55A};

        reset      = 1'b1;
        req_valid  = 2'b11;
        req_valid3 = 2'b11;
        req_op     = '0;
        req_ch     = 4'b0101;
        req_mode   = '0;
        req_bcd    = '0;
        req_value  = 32'h1234_5678;

        // Outputs while reset is held, even with requests pending.
        repeat (3) @(negedge clk);
        #1;
        check("reset ready", 32'(req_ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset bus", 32'({pit_cs, pit_rd, pit_wr, pit_a, pit_wdata}), 32'd0);
        check("reset rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'd0);
        check("reset ready3", 32'(req_ready3), 32'd0);
        req_valid  = 2'b00;
        req_valid3 = 2'b00;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++)
            run_vec(i, vecs[i]);

        // Both requesters pending: grants alternate from requester 0, 8 cycles apart.
        do_reset();
        drive(vecs[0]);
        drive(vecs[2]);
        req_valid = 2'b11;
        last_cyc  = 0;
        for (int g = 0; g < 4; g++) begin
            found = 0;
            for (int w = 0; w < 20 && found == 0; w++) begin
                #1;
                if (|req_ready) found = 1;
                else @(negedge clk);
            end
            check($sformatf("rr grant%0d seen", g), 32'(found), 32'd1);
            if (found != 0) begin
                check($sformatf("rr grant%0d", g), 32'(req_ready),
                      (g % 2 == 0) ? 32'd1 : 32'd2);
                if (g > 0)
                    check($sformatf("rr spacing%0d", g), 32'(cyc - last_cyc), 32'd8);
                last_cyc = cyc;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        repeat (10) @(negedge clk);

        // Reset during B0GAP abandons the command.
        drive(vecs[0]);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        check("abort b0gap idle", 32'({pit_cs, busy}), 32'b01);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("abort quiet k%0d", k), 32'({pit_cs, pit_rd, pit_wr, rsp_valid}),
                  32'd0);
            @(negedge clk);
        end
        run_vec(7, vecs[0]);

        // GAP=3: strobes at T+1, T+5, T+9, completion at T+13.
        @(negedge clk);
        drive(vecs[0]);
        req_valid3 = 2'b01;
        #1;
        check("g3 ready", 32'(req_ready3), 32'd1);
        @(negedge clk);
        req_valid3 = 2'b00;
        for (int k = 1; k <= 14; k++) begin
            e3 = (k == 1 || k == 5 || k == 9) ? 3'b101 : 3'b000;
            check($sformatf("g3 strobes k%0d", k), 32'({pit_cs3, pit_rd3, pit_wr3}), 32'(e3));
            if (k == 5)
                check("g3 b0 data", 32'({pit_a3, pit_wdata3}), 32'({2'd1, 8'h34}));
            if (k == 9)
                check("g3 b1 data", 32'({pit_a3, pit_wdata3}), 32'({2'd1, 8'h12}));
            check($sformatf("g3 rsp_valid k%0d", k), 32'(rsp_valid3),
                  (k == 13) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
